// File: rtl/hamming_secded_serial_decoder_if.sv
// Bit-serial input strobes and decoded-word/status outputs of the Hamming decoder.
interface hamming_secded_serial_decoder_if #(
  parameter int M     = 3,
  parameter int CNT_W = 8
);
  localparam int N = (1 << M) - 1;
  localparam int K = N - M;

  logic             ena;
  logic             decode_in;
  logic             sync_in;
  logic             clr_cnt;
  logic [K-1:0]     decode_out;
  logic             valid_out;
  logic             err_corrected;
  logic             err_uncorrectable;
  logic [M-1:0]     syndrome_out;
  logic             frame_abort;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output ena, decode_in, sync_in, clr_cnt,
    input  decode_out, valid_out, err_corrected, err_uncorrectable,
           syndrome_out, frame_abort, err_cnt
  );

  modport slave (
    input  ena, decode_in, sync_in, clr_cnt,
    output decode_out, valid_out, err_corrected, err_uncorrectable,
           syndrome_out, frame_abort, err_cnt
  );
endinterface

// File: rtl/hamming_secded_serial_decoder.sv
// Serial Hamming SEC / SECDED decoder: incremental syndrome per received bit,
// one-cycle decode stage, registered outputs and a saturating error counter.
module hamming_secded_serial_decoder #(
  parameter int M      = 3,
  parameter int SECDED = 1,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  hamming_secded_serial_decoder_if.slave bus
);
  localparam int N  = (1 << M) - 1;
  localparam int K  = N - M;
  localparam int PW = $clog2(N + 2);
  localparam logic [PW-1:0] POS_FIRST = PW'(1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N);

  // Codeword position carried by the idx-th data bit (non-powers of two, ascending).
  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  typedef enum logic [1:0] {ST_FIRST, ST_BODY, ST_PARITY} rx_state_t;

  rx_state_t        r_state, w_state_next;
  logic [PW-1:0]    r_pos, w_pos_next;
  logic [M-1:0]     r_syn, w_syn_next;
  logic             r_par, w_par_next;
  logic [K-1:0]     r_data, w_data_next;
  logic             r_abort, w_abort_next;
  logic             w_load;
  logic [M-1:0]     w_final_syn;
  logic             w_final_par;

  logic             r_stage_vld;
  logic [K-1:0]     r_stage_data;
  logic [M-1:0]     r_stage_syn;
  logic             r_stage_par;

  logic             r_valid;
  logic [K-1:0]     r_decode_out;
  logic             r_err_corr;
  logic             r_err_unc;
  logic [M-1:0]     r_syndrome;
  logic [CNT_W-1:0] r_err_cnt;

  logic [K-1:0]     w_dpos_hit;
  logic [K-1:0]     w_fixed_data;
  logic             w_syn_nz;
  logic             w_fix;
  logic             w_corr;
  logic             w_unc;

  for (genvar gi = 0; gi < K; gi++) begin : g_dpos
    localparam int DP = data_pos(gi);
    assign w_dpos_hit[gi]   = (r_pos == PW'(DP));
    assign w_fixed_data[gi] = r_stage_data[gi] ^ (w_fix && (r_stage_syn == M'(DP)));
  end

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_syn_next   = r_syn;
    w_par_next   = r_par;
    w_data_next  = r_data;
    w_abort_next = 1'b0;
    w_load       = 1'b0;
    w_final_syn  = r_syn;
    w_final_par  = r_par;
    if (bus.ena) begin
      if (bus.sync_in || (r_state == ST_FIRST)) begin
        // Position 1 is a parity bit, so a restart only reseeds syndrome and parity.
        w_abort_next = bus.sync_in && (r_state != ST_FIRST);
        w_syn_next   = bus.decode_in ? M'(1) : '0;
        w_par_next   = bus.decode_in;
        w_pos_next   = PW'(2);
        w_state_next = ST_BODY;
      end else if (r_state == ST_BODY) begin
        w_final_syn = r_syn ^ (bus.decode_in ? r_pos[M-1:0] : '0);
        w_final_par = r_par ^ bus.decode_in;
        for (int i = 0; i < K; i++) begin
          if (w_dpos_hit[i]) w_data_next[i] = bus.decode_in;
        end
        if (r_pos == POS_LAST) begin
          w_pos_next = POS_FIRST;
          if (SECDED != 0) begin
            w_state_next = ST_PARITY;
            w_syn_next   = w_final_syn;
            w_par_next   = w_final_par;
          end else begin
            w_state_next = ST_FIRST;
            w_load       = 1'b1;
            w_syn_next   = '0;
            w_par_next   = 1'b0;
          end
        end else begin
          w_pos_next = r_pos + PW'(1);
          w_syn_next = w_final_syn;
          w_par_next = w_final_par;
        end
      end else begin
        w_final_par  = r_par ^ bus.decode_in;
        w_load       = 1'b1;
        w_state_next = ST_FIRST;
        w_syn_next   = '0;
        w_par_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FIRST;
      r_pos        <= POS_FIRST;
      r_syn        <= '0;
      r_par        <= 1'b0;
      r_data       <= '0;
      r_abort      <= 1'b0;
      r_stage_vld  <= 1'b0;
      r_stage_data <= '0;
      r_stage_syn  <= '0;
      r_stage_par  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pos       <= w_pos_next;
      r_syn       <= w_syn_next;
      r_par       <= w_par_next;
      r_data      <= w_data_next;
      r_abort     <= w_abort_next;
      r_stage_vld <= w_load;
      if (w_load) begin
        r_stage_data <= w_data_next;
        r_stage_syn  <= w_final_syn;
        r_stage_par  <= w_final_par;
      end
    end
  end

  assign w_syn_nz = |r_stage_syn;

  if (SECDED != 0) begin : g_secded
    // Odd overall parity means one flipped bit (possibly the parity bit itself).
    assign w_corr = r_stage_par;
    assign w_unc  = w_syn_nz & ~r_stage_par;
    assign w_fix  = w_syn_nz & r_stage_par;
  end else begin : g_sec
    assign w_corr = w_syn_nz;
    assign w_unc  = 1'b0;
    assign w_fix  = w_syn_nz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_decode_out <= '0;
      r_err_corr   <= 1'b0;
      r_err_unc    <= 1'b0;
      r_syndrome   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_valid <= r_stage_vld;
      if (r_stage_vld) begin
        r_decode_out <= w_fixed_data;
        r_err_corr   <= w_corr;
        r_err_unc    <= w_unc;
        r_syndrome   <= r_stage_syn;
      end
      // The count advances on the edge closing the valid_out cycle, so clr_cnt held
      // during that cycle wins over the increment.
      if (bus.clr_cnt) begin
        r_err_cnt <= '0;
      end else if (r_valid && (r_err_corr || r_err_unc) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.decode_out        = r_decode_out;
  assign bus.valid_out         = r_valid;
  assign bus.err_corrected     = r_err_corr;
  assign bus.err_uncorrectable = r_err_unc;
  assign bus.syndrome_out      = r_syndrome;
  assign bus.frame_abort       = r_abort;
  assign bus.err_cnt           = r_err_cnt;
endmodule

// File: tb/tb_hamming_secded_serial_decoder.sv
// Randomised and directed bench for the serial SECDED decoder (M=3, SECDED=1, CNT_W=2).
module tb_hamming_secded_serial_decoder;
  localparam int M      = 3;
  localparam int SECDED = 1;
  localparam int CNT_W  = 2;
  localparam int N      = 7;
  localparam int K      = 4;
  localparam int FRAME  = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  hamming_secded_serial_decoder_if #(.M(M), .CNT_W(CNT_W)) bus ();

  hamming_secded_serial_decoder #(.M(M), .SECDED(SECDED), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Streams are written first-bit-first: stream[7] is position 1, stream[0] the overall parity.
  function automatic void model(input logic [7:0] stream, output logic [K-1:0] data,
                                output logic corr, output logic unc, output logic [M-1:0] syn);
    logic cw [1:7];
    int   s;
    int   idx;
    logic par;
    s   = 0;
    par = stream[0];
    for (int p = 1; p <= N; p++) begin
      cw[p] = stream[FRAME-p];
      if (cw[p]) s = s ^ p;
      par = par ^ cw[p];
    end
    corr = par;
    unc  = (s != 0) && !par;
    if (s != 0 && par) cw[s] = ~cw[s];
    idx  = 0;
    data = '0;
    for (int p = 1; p <= N; p++) begin
      if ($countones(p) != 1) begin
        data[idx] = cw[p];
        idx++;
      end
    end
    syn = M'(s);
  endfunction

  function automatic logic [7:0] encode(input logic [K-1:0] d);
    logic       cw [1:7];
    int         idx;
    int         pp;
    logic       x;
    logic       ov;
    logic [7:0] st;
    idx = 0;
    for (int p = 1; p <= N; p++) begin
      cw[p] = 1'b0;
      if ($countones(p) != 1) begin
        cw[p] = d[idx];
        idx++;
      end
    end
    for (int j = 0; j < M; j++) begin
      pp = 1 << j;
      x  = 1'b0;
      for (int q = 1; q <= N; q++) if (q != pp && (q & pp) != 0) x = x ^ cw[q];
      cw[pp] = x;
    end
    ov = 1'b0;
    for (int p = 1; p <= N; p++) begin
      ov = ov ^ cw[p];
      st[FRAME-p] = cw[p];
    end
    st[0] = ov;
    return st;
  endfunction

  task automatic drive_bit(input logic b, input logic s);
    bus.ena       = 1'b1;
    bus.decode_in = b;
    bus.sync_in   = s;
    @(negedge clk);
    bus.ena     = 1'b0;
    bus.sync_in = 1'b0;
  endtask

  task automatic bump_cnt(input logic err);
    if (err && exp_cnt < 3) exp_cnt++;
  endtask

  task automatic send_frame(input string name, input logic [7:0] stream, input bit sync_first,
                            input bit gaps, input bit expect_abort, input bit clr_on_valid);
    logic [K-1:0] ed;
    logic         ec, eu;
    logic [M-1:0] es;
    int           lat;
    model(stream, ed, ec, eu, es);
    for (int i = 0; i < FRAME; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_bit(stream[FRAME-1-i], sync_first && (i == 0));
      if (i == 0 && sync_first) begin
        n_checks++;
        if (bus.frame_abort !== expect_abort)
          $display("FAIL %s abort_pulse got=%b want=%b", name, bus.frame_abort, expect_abort);
        else n_pass++;
      end
      if (i == 1) begin
        n_checks++;
        if (bus.frame_abort !== 1'b0)
          $display("FAIL %s abort_width got=%b want=0", name, bus.frame_abort);
        else n_pass++;
      end
    end
    lat = 0;
    while (bus.valid_out !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 1) $display("FAIL %s latency got=%0d want=1", name, lat);
    else n_pass++;
    n_checks++;
    if (bus.decode_out !== ed || bus.err_corrected !== ec || bus.err_uncorrectable !== eu ||
        bus.syndrome_out !== es)
      $display("FAIL %s decode got=%b/%b/%b/%0d want=%b/%b/%b/%0d", name, bus.decode_out,
               bus.err_corrected, bus.err_uncorrectable, bus.syndrome_out, ed, ec, eu, es);
    else n_pass++;
    if (clr_on_valid) begin
      bus.clr_cnt = 1'b1;
      exp_cnt = 0;
    end else begin
      bump_cnt(ec || eu);
    end
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    n_checks++;
    if (bus.valid_out !== 1'b0 || bus.decode_out !== ed)
      $display("FAIL %s pulse_hold valid=%b data=%b want valid=0 data=%b", name, bus.valid_out,
               bus.decode_out, ed);
    else n_pass++;
    n_checks++;
    if (bus.err_cnt !== CNT_W'(exp_cnt))
      $display("FAIL %s err_cnt got=%0d want=%0d", name, bus.err_cnt, exp_cnt);
    else n_pass++;
    $display("frame %s stream=%b data=%b corr=%b unc=%b syn=%0d cnt=%0d", name, stream,
             bus.decode_out, bus.err_corrected, bus.err_uncorrectable, bus.syndrome_out,
             bus.err_cnt);
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (bus.decode_out !== '0 || bus.valid_out !== 1'b0 || bus.err_corrected !== 1'b0 ||
        bus.err_uncorrectable !== 1'b0 || bus.syndrome_out !== '0 ||
        bus.frame_abort !== 1'b0 || bus.err_cnt !== '0)
      $display("FAIL %s outputs got=%b/%b/%b/%b/%0d/%b/%0d want all zero", name, bus.decode_out,
               bus.valid_out, bus.err_corrected, bus.err_uncorrectable, bus.syndrome_out,
               bus.frame_abort, bus.err_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_directed();
    send_frame("clean", 8'b10101010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame("single_pos6", 8'b10101110, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame("double_pos2_5", 8'b11100010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame("overall_par", 8'b10101011, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    for (int rep = 0; rep < 3; rep++) begin
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      send_frame(rep == 0 ? "abort" : "abort_gaps", 8'b10101010, 1'b1, rep != 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]   sa, sb;
    logic [K-1:0] eda, edb;
    logic         eca, eua, ecb, eub;
    logic [M-1:0] esa, esb;
    int           lat;
    sa = 8'b10101110;
    sb = 8'b10101010;
    model(sa, eda, eca, eua, esa);
    model(sb, edb, ecb, eub, esb);
    for (int i = 0; i < FRAME; i++) drive_bit(sa[FRAME-1-i], i == 0);
    drive_bit(sb[FRAME-1], 1'b1);
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.decode_out !== eda || bus.err_corrected !== eca ||
        bus.syndrome_out !== esa || bus.frame_abort !== 1'b0)
      $display("FAIL b2b_first got v=%b d=%b c=%b s=%0d a=%b want v=1 d=%b c=%b s=%0d a=0",
               bus.valid_out, bus.decode_out, bus.err_corrected, bus.syndrome_out,
               bus.frame_abort, eda, eca, esa);
    else n_pass++;
    bump_cnt(eca || eua);
    for (int i = 1; i < FRAME; i++) drive_bit(sb[FRAME-1-i], 1'b0);
    lat = 0;
    while (bus.valid_out !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 1 || bus.decode_out !== edb || bus.err_corrected !== ecb ||
        bus.err_uncorrectable !== eub)
      $display("FAIL b2b_second lat=%0d d=%b c=%b u=%b want lat=1 d=%b c=%b u=%b", lat,
               bus.decode_out, bus.err_corrected, bus.err_uncorrectable, edb, ecb, eub);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.err_cnt !== CNT_W'(exp_cnt))
      $display("FAIL b2b_cnt got=%0d want=%0d", bus.err_cnt, exp_cnt);
    else n_pass++;
    $display("frame b2b data=%b cnt=%0d", bus.decode_out, bus.err_cnt);
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 5; i++) send_frame("saturate", 8'b10101110, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.err_cnt !== 2'd3) $display("FAIL saturate got=%0d want=3", bus.err_cnt);
    else n_pass++;
    send_frame("clear_on_valid", 8'b10101110, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    send_frame("pre_reset", 8'b10101110, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame("post_reset", 8'b10101010, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [K-1:0] d;
    logic [7:0]   st;
    int           nerr, e1, e2;
    for (int it = 0; it < 24; it++) begin
      d    = K'($urandom);
      st   = encode(d);
      nerr = $urandom_range(0, 2);
      e1   = $urandom_range(0, 7);
      e2   = (e1 + 1 + $urandom_range(0, 6)) % 8;
      if (nerr >= 1) st[e1] = ~st[e1];
      if (nerr == 2) st[e2] = ~st[e2];
      send_frame("random", st, it[0], 1'b1, 1'b0, 1'b0);
      if (nerr <= 1) begin
        n_checks++;
        if (bus.decode_out !== d)
          $display("FAIL random_orig got=%b want=%b", bus.decode_out, d);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.ena       = 1'b0;
    bus.decode_in = 1'b0;
    bus.sync_in   = 1'b0;
    bus.clr_cnt   = 1'b0;
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
